// File: rtl/uart_tx_fifo_ctrl.sv
// ============================================================================
// Module  : uart_tx_fifo_ctrl
// Brief   : Byte FIFO feeding uart_tx; launches one byte per tx_done_tick.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo_ctrl #(
    parameter int DBIT   = 8,
    parameter int ADDR_W = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr_en,
    input  logic [DBIT-1:0]   i_wr_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W:0]   o_count,
    output logic              o_overflow,
    output logic              o_busy,
    output logic              o_tx_start,
    output logic [DBIT-1:0]   o_tx_data,
    input  logic              i_tx_done_tick
);

    localparam int                c_DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   c_FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   c_CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_PTR_ONE  = ADDR_W'(1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;

    logic [DBIT-1:0]   r_mem [c_DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic [1:0]        r_state;
    logic              r_overflow;
    logic              r_tx_start;
    logic [DBIT-1:0]   r_tx_data;

    logic w_full;
    logic w_empty;
    logic w_wr_acc;
    logic w_pop;

    // Full is taken from the registered count, so a same-cycle pop never makes room.
    assign w_full   = (r_count == c_FULL_CNT);
    assign w_empty  = (r_count == '0);
    assign w_wr_acc = i_wr_en && !w_full;
    assign w_pop    = (r_state == c_IDLE) && !w_empty;

    always_ff @(posedge i_clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= i_wr_en && w_full;
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_wr_acc, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Launch sequencer: tx_data stays put from launch until the next pop.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state    <= c_IDLE;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_pop) begin
                        r_tx_data  <= r_mem[r_rd_ptr];
                        r_tx_start <= 1'b1;
                        r_state    <= c_START;
                    end else begin
                        r_tx_start <= 1'b0;
                    end
                end
                c_START: begin
                    r_tx_start <= 1'b0;
                    r_state    <= c_WAIT;
                end
                c_WAIT: begin
                    r_tx_start <= 1'b0;
                    if (i_tx_done_tick) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_tx_start <= 1'b0;
                    r_state    <= c_IDLE;
                end
            endcase
        end
    end

    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;
    assign o_busy     = (r_state == c_START) || (r_state == c_WAIT);
    assign o_tx_start = r_tx_start;
    assign o_tx_data  = r_tx_data;

endmodule

`default_nettype wire
